seg_scan_driver: RTL

- Consumer end of the 20-bit `disp` glyph bus: takes four 5-bit glyph codes plus per-digit decimal points and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Sits between the top-level mode controller (source of `disp`) and the board pins.
- Owns the scan timing, the per-frame shadow latch (no tearing), anode dead-time (no ghosting) and glyph-to-segment decoding.

---
 rtl/seg_pkg.sv | 57 +++++
 rtl/seg_glyph_decode.sv | 48 ++++
 rtl/seg_scan_driver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Glyph codes, active-low segment patterns ({g,f,e,d,c,b,a}) and types shared by the scan driver.
package seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [4:0] glyph_t;

  localparam glyph_t GLYPH_E      = 5'd14;
  localparam glyph_t GLYPH_DASH   = 5'd16;
  localparam glyph_t GLYPH_H      = 5'd17;
  localparam glyph_t GLYPH_L      = 5'd18;
  localparam glyph_t GLYPH_P      = 5'd19;
  localparam glyph_t GLYPH_U      = 5'd20;
  localparam glyph_t GLYPH_N      = 5'd21;
  localparam glyph_t GLYPH_O      = 5'd22;
  localparam glyph_t GLYPH_Y      = 5'd23;
  localparam glyph_t GLYPH_H_LC   = 5'd24;
  localparam glyph_t GLYPH_R      = 5'd25;
  localparam glyph_t GLYPH_T      = 5'd26;
  localparam glyph_t GLYPH_USCORE = 5'd27;
  localparam glyph_t GLYPH_J      = 5'd28;
  localparam glyph_t GLYPH_I      = 5'd29;
  localparam glyph_t GLYPH_NUL    = 5'd30;
  localparam glyph_t GLYPH_BLANK  = 5'd31;

  localparam seg_t SEG_0      = 7'b1000000;
  localparam seg_t SEG_1      = 7'b1111001;
  localparam seg_t SEG_2      = 7'b0100100;
  localparam seg_t SEG_3      = 7'b0110000;
  localparam seg_t SEG_4      = 7'b0011001;
  localparam seg_t SEG_5      = 7'b0010010;
  localparam seg_t SEG_6      = 7'b0000010;
  localparam seg_t SEG_7      = 7'b1111000;
  localparam seg_t SEG_8      = 7'b0000000;
  localparam seg_t SEG_9      = 7'b0010000;
  localparam seg_t SEG_A      = 7'b0001000;
  localparam seg_t SEG_B_LC   = 7'b0000011;
  localparam seg_t SEG_C      = 7'b1000110;
  localparam seg_t SEG_D_LC   = 7'b0100001;
  localparam seg_t SEG_E      = 7'b0000110;
  localparam seg_t SEG_F      = 7'b0001110;
  localparam seg_t SEG_DASH   = 7'b0111111;
  localparam seg_t SEG_H      = 7'b0001001;
  localparam seg_t SEG_L      = 7'b1000111;
  localparam seg_t SEG_P      = 7'b0001100;
  localparam seg_t SEG_U      = 7'b1000001;
  localparam seg_t SEG_N_LC   = 7'b0101011;
  localparam seg_t SEG_O_LC   = 7'b0100011;
  localparam seg_t SEG_Y_LC   = 7'b0010001;
  localparam seg_t SEG_H_LC   = 7'b0001011;
  localparam seg_t SEG_R_LC   = 7'b0101111;
  localparam seg_t SEG_T_LC   = 7'b0000111;
  localparam seg_t SEG_USCORE = 7'b1110111;
  localparam seg_t SEG_J      = 7'b1100001;
  localparam seg_t SEG_I      = 7'b1111001;
  localparam seg_t SEG_BLANK  = 7'b1111111;

endpackage

// File: rtl/seg_glyph_decode.sv
// Glyph code to active-low segment pattern; purely combinational, zero latency, no backpressure.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  glyph_t code,
  output seg_t   seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'd0:         seg = SEG_0;
      5'd1:         seg = SEG_1;
      5'd2:         seg = SEG_2;
      5'd3:         seg = SEG_3;
      5'd4:         seg = SEG_4;
      5'd5:         seg = SEG_5;
      5'd6:         seg = SEG_6;
      5'd7:         seg = SEG_7;
      5'd8:         seg = SEG_8;
      5'd9:         seg = SEG_9;
      5'd10:        seg = SEG_A;
      5'd11:        seg = SEG_B_LC;
      5'd12:        seg = SEG_C;
      5'd13:        seg = SEG_D_LC;
      GLYPH_E:      seg = SEG_E;
      5'd15:        seg = SEG_F;
      GLYPH_DASH:   seg = SEG_DASH;
      GLYPH_H:      seg = SEG_H;
      GLYPH_L:      seg = SEG_L;
      GLYPH_P:      seg = SEG_P;
      GLYPH_U:      seg = SEG_U;
      GLYPH_N:      seg = SEG_N_LC;
      GLYPH_O:      seg = SEG_O_LC;
      GLYPH_Y:      seg = SEG_Y_LC;
      GLYPH_H_LC:   seg = SEG_H_LC;
      GLYPH_R:      seg = SEG_R_LC;
      GLYPH_T:      seg = SEG_T_LC;
      GLYPH_USCORE: seg = SEG_USCORE;
      GLYPH_J:      seg = SEG_J;
      GLYPH_I:      seg = SEG_I;
      GLYPH_NUL:    seg = SEG_BLANK;
      GLYPH_BLANK:  seg = SEG_BLANK;
      default:      seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed common-anode 7-seg driver with per-frame shadow latch and anode dead-time.
// Pins registered, 1 cycle after scan state; no backpressure (disp level-sampled per frame); SEG_BLINK_EN adds blink.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] disp,
  input  logic [3:0]  dp_in,
`ifdef SEG_BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  output logic [3:0]  an,
  output seg_t        seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int DIV = CLK_HZ / (SCAN_HZ * 4);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("seg_scan_driver: digit slot must be at least 2 cycles");
    end
    if (DEAD_CYCLES < 1 || DEAD_CYCLES >= DIV) begin : g_bad_dead
      $error("seg_scan_driver: dead time must be within 1..DIV-1");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("seg_scan_driver: blink half-period must be at least 1 frame");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [19:0]   sh_disp;
  logic [3:0]    sh_dp;
  logic          slot_last;
  logic          frame_go;
  logic          dead;
  logic          blank;
  glyph_t        glyph;
  seg_t          dec_seg;

  assign slot_last = (cnt == CW'(DIV - 1));
  assign frame_go  = (cnt == '0) && (idx == 2'd0);
  assign dead      = (cnt < CW'(DEAD_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_last) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow only updates in slot 0's dead window, so a lit digit never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_disp <= {4{GLYPH_BLANK}};
      sh_dp   <= 4'h0;
    end else if (frame_go) begin
      sh_disp <= disp;
      sh_dp   <= dp_in;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [3:0]    sh_mask;

  // frame_cnt counts latches within the current half-period; phase flips on
  // the latch that opens the next one, so frames 0..BLINK_FRAMES-1 stay visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_mask     <= 4'h0;
    end else if (frame_go) begin
      sh_mask <= blink_mask;
      if (frame_cnt == FW'(BLINK_FRAMES)) begin
        frame_cnt   <= FW'(1);
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blank = blink_phase & sh_mask[idx];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    glyph = sh_disp[4:0];
    case (idx)
      2'd0: glyph = sh_disp[4:0];
      2'd1: glyph = sh_disp[9:5];
      2'd2: glyph = sh_disp[14:10];
      2'd3: glyph = sh_disp[19:15];
      default: glyph = sh_disp[4:0];
    endcase
  end

  seg_glyph_decode u_decode (
    .code (glyph),
    .seg  (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= 4'hF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_go;
      if (dead) begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= blank ? SEG_BLANK : dec_seg;
        dp  <= blank | ~sh_dp[idx];
      end
    end
  end

endmodule
